// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic-computer sequence controller:
// common-bus select codes, ALU operation codes, opcode indices and the strobe bundle.
package mano_pkg;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [1:0] ALU_AND     = 2'd0;
    localparam logic [1:0] ALU_ADD     = 2'd1;
    localparam logic [1:0] ALU_PASS_DR = 2'd2;

    localparam int D_AND = 0;
    localparam int D_ADD = 1;
    localparam int D_LDA = 2;
    localparam int D_STA = 3;
    localparam int D_BUN = 4;
    localparam int D_BSA = 5;
    localparam int D_ISZ = 6;
    localparam int D_REG = 7;

    // Every datapath control produced in one timing step.
    typedef struct packed {
        logic [2:0] bus_sel;
        logic       ar_ld;
        logic       ar_inc;
        logic       pc_ld;
        logic       pc_inc;
        logic       dr_ld;
        logic       dr_inc;
        logic       ir_ld;
        logic       ac_ld;
        logic [1:0] alu_op;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_exec;
    } ctrl_s;

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter SC with clear/increment and the one-hot timing decoder.
// Held at zero while disabled; clears itself at its terminal count.
module mano_seq_counter #(
    parameter int SC_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic [2**SC_W-1:0]   t
);

    localparam logic [SC_W-1:0] SC_MAX = '1;

    logic [SC_W-1:0] sc;
    logic            wrap_guard;

    // Reaching the last state without a clear would otherwise wrap into a bogus T0.
    assign wrap_guard = (sc == SC_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= '0;
        end else if (!en || clr || wrap_guard) begin
            sc <= '0;
        end else begin
            sc <= sc + 1'b1;
        end
    end

    always_comb begin
        t = '0;
        if (en) begin
            t[sc] = 1'b1;
        end
    end

    a_no_terminal_count: assert property (
        @(posedge clk) disable iff (!rst_n) !(en && !clr && wrap_guard)
    );

endmodule

// File: rtl/mano_seq_ctrl.sv
// Mano basic-computer sequence controller: S/I/opcode state, SC timing and
// Moore decode of fetch, decode, indirect and memory-reference execute strobes.
module mano_seq_ctrl
    import mano_pkg::*;
#(
    parameter int SC_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           ir_op,
    input  logic                 ir_i,
    input  logic                 ir_b0,
    input  logic                 dr_zero,
    output logic                 running,
    output logic [2**SC_W-1:0]   t,
    output logic [7:0]           d,
    output logic [2:0]           bus_sel,
    output logic                 ar_ld,
    output logic                 ar_inc,
    output logic                 pc_ld,
    output logic                 pc_inc,
    output logic                 dr_ld,
    output logic                 dr_inc,
    output logic                 ir_ld,
    output logic                 ac_ld,
    output logic [1:0]           alu_op,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 reg_exec
);

    logic       s_q, s_d;
    logic       i_q, i_d;
    logic [2:0] op_q, op_d;
    logic       sc_clr;
    ctrl_s      c;

    mano_seq_counter #(.SC_W(SC_W)) u_sc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s_q),
        .clr   (sc_clr),
        .t     (t)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= 1'b0;
            i_q  <= 1'b0;
            op_q <= 3'd0;
        end else begin
            s_q  <= s_d;
            i_q  <= i_d;
            op_q <= op_d;
        end
    end

    always_comb begin
        s_d  = s_q;
        i_d  = i_q;
        op_d = op_q;
        if (!s_q && start) begin
            s_d = 1'b1;
        end
        if (t[2]) begin
            i_d  = ir_i;
            op_d = ir_op;
        end
        // HLT is a register-reference instruction (direct) with IR[0] set.
        if (t[3] && d[D_REG] && !i_q && ir_b0) begin
            s_d = 1'b0;
        end
    end

    assign running = s_q;
    assign d       = s_q ? (8'd1 << op_q) : 8'd0;

    always_comb begin
        c      = '0;
        sc_clr = 1'b0;
        if (t[0]) begin
            c.bus_sel = BUS_PC;
            c.ar_ld   = 1'b1;
        end
        if (t[1]) begin
            c.bus_sel = BUS_MEM;
            c.mem_rd  = 1'b1;
            c.ir_ld   = 1'b1;
            c.pc_inc  = 1'b1;
        end
        if (t[2]) begin
            c.bus_sel = BUS_IR;
            c.ar_ld   = 1'b1;
        end
        if (t[3]) begin
            if (d[D_REG]) begin
                c.reg_exec = 1'b1;
                sc_clr     = 1'b1;
            end else if (i_q) begin
                c.bus_sel = BUS_MEM;
                c.mem_rd  = 1'b1;
                c.ar_ld   = 1'b1;
            end
        end
        if (t[4]) begin
            if (d[D_AND] || d[D_ADD] || d[D_LDA] || d[D_ISZ]) begin
                c.bus_sel = BUS_MEM;
                c.mem_rd  = 1'b1;
                c.dr_ld   = 1'b1;
            end else if (d[D_STA]) begin
                c.bus_sel = BUS_AC;
                c.mem_wr  = 1'b1;
                sc_clr    = 1'b1;
            end else if (d[D_BUN]) begin
                c.bus_sel = BUS_AR;
                c.pc_ld   = 1'b1;
                sc_clr    = 1'b1;
            end else if (d[D_BSA]) begin
                c.bus_sel = BUS_PC;
                c.mem_wr  = 1'b1;
                c.ar_inc  = 1'b1;
            end
        end
        if (t[5]) begin
            if (d[D_AND] || d[D_ADD] || d[D_LDA]) begin
                c.ac_ld  = 1'b1;
                c.alu_op = d[D_AND] ? ALU_AND : (d[D_ADD] ? ALU_ADD : ALU_PASS_DR);
                sc_clr   = 1'b1;
            end else if (d[D_BSA]) begin
                c.bus_sel = BUS_AR;
                c.pc_ld   = 1'b1;
                sc_clr    = 1'b1;
            end else if (d[D_ISZ]) begin
                c.dr_inc = 1'b1;
            end
        end
        // dr_zero already reflects the value incremented at T5.
        if (t[6] && d[D_ISZ]) begin
            c.bus_sel = BUS_DR;
            c.mem_wr  = 1'b1;
            c.pc_inc  = dr_zero;
            sc_clr    = 1'b1;
        end
    end

    assign bus_sel  = c.bus_sel;
    assign ar_ld    = c.ar_ld;
    assign ar_inc   = c.ar_inc;
    assign pc_ld    = c.pc_ld;
    assign pc_inc   = c.pc_inc;
    assign dr_ld    = c.dr_ld;
    assign dr_inc   = c.dr_inc;
    assign ir_ld    = c.ir_ld;
    assign ac_ld    = c.ac_ld;
    assign alu_op   = c.alu_op;
    assign mem_rd   = c.mem_rd;
    assign mem_wr   = c.mem_wr;
    assign reg_exec = c.reg_exec;

endmodule

// File: doc/mano_seq_ctrl.md
Name: mano_seq_ctrl

Overview:
- Sequence controller for the Mano basic computer.
- Owns the sequence counter (SC), start/stop flip-flop (S), latched indirect bit (I) and latched opcode.
- Emits the one-hot timing (T) and decoded-opcode (D) vectors plus per-cycle load/inc/clr, bus-select and memory strobes for the fetch, decode, indirect and memory-reference execute cycles.
- Sits between IR/DR flags and the AR/PC/DR/IR/AC/memory datapath; it replaces the per-register hand-written control equations.

Parameters:
- SC_W, 3, sequence-counter width; T vector is 2**SC_W bits; SC_W must be at least 3.

Ports:
- clk      in   1     rising-edge clock
- rst_n    in   1     asynchronous active-low reset
- start    in   1     one-cycle pulse; sets S when stopped
- ir_op    in   3     IR[14:12]
- ir_i     in   1     IR[15]
- ir_b0    in   1     IR[0] (HLT bit)
- dr_zero  in   1     DR == 0
- running  out  1     S flip-flop
- t        out  2**SC_W  one-hot timing; all zero when stopped
- d        out  8     one-hot latched opcode; valid from T3
- bus_sel  out  3     common-bus select (codes in package)
- ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ir_ld, ac_ld  out  1 each
- alu_op   out  2     AND / ADD / PASS_DR
- mem_rd, mem_wr  out  1 each
- reg_exec out  1     D7 & T3 pulse to the register-reference/IO unit

Behaviour:
- Reset: asynchronous and active-low on rst_n; one clock, clk. While reset is asserted: S=0, SC=0, I=0, opcode=0. All outputs are 0, including t and d.
- Stopped (S=0): SC is held at 0, t=0, all strobes are 0. A start pulse sets S at the next edge, and T0 appears in the following cycle (latency 1). start is ignored while S=1.
- Running: SC increments every cycle unless sc_clr is asserted, in which case SC loads 0 (next cycle is T0). sc_clr is internal.
- Fetch and decode, with bus_sel codes AR=1, PC=2, DR=3, AC=4, IR=5, MEM=7:
  - T0: bus=PC, ar_ld.
  - T1: bus=MEM, mem_rd, ir_ld, pc_inc.
  - T2: bus=IR, ar_ld. At the T2 edge, latch opcode←ir_op and I←ir_i. d becomes valid from T3.
  - T3, D7: reg_exec, sc_clr. If ~I & ir_b0 (HLT), S is cleared at the same edge.
  - T3, ~D7 & I: bus=MEM, mem_rd, ar_ld.
  - T3, ~D7 & ~I: no strobes.
- Memory-reference execute:
  - D0/D1/D2/D6 at T4: bus=MEM, mem_rd, dr_ld.
  - D0 T5: ac_ld, alu_op=AND, sc_clr. D1 T5: ADD. D2 T5: PASS_DR.
  - D3 T4: bus=AC, mem_wr, sc_clr.
  - D4 T4: bus=AR, pc_ld, sc_clr.
  - D5 T4: bus=PC, mem_wr, ar_inc. D5 T5: bus=AR, pc_ld, sc_clr.
  - D6 T5: dr_inc. D6 T6: bus=DR, mem_wr, pc_inc iff dr_zero (sampled at T6, after the T5 increment), sc_clr.
- Outputs are Moore: combinational from registered SC, S, I and opcode only. dr_zero affects only pc_inc at D6 T6. No output depends on start.
- Only one of bus/ld strobes per destination is active per cycle. mem_rd and mem_wr are never asserted together.
- Safety: if SC reaches 2**SC_W−1 without a clear, force sc_clr (no silent wrap into T0 misdecode). This is unreachable in legal operation; assert it in sim.
- Reset mid-instruction: everything returns to the reset state immediately. The next start restarts at T0, with no partial instruction resumed.

Decomposition:
- Package mano_pkg holds:
  - bus-select localparams: BUS_AR=1, BUS_PC=2, BUS_DR=3, BUS_AC=4, BUS_IR=5, BUS_MEM=7
  - alu_op codes: AND=0, ADD=1, PASS_DR=2
  - opcode indices D_AND..D_REG = 0..7
- One natural sub-module, mano_seq_counter: SC register with clr/inc and the one-hot T decoder, parameterised by SC_W.
- The strobe decode stays in the top module.

Test Plan:
- Reset, then start pulse at cycle 0 → running=1 at cycle 1 with t=0x01. T0: bus_sel=2, ar_ld=1. T1: mem_rd, ir_ld, pc_inc.
- LDA direct (ir_op=2, ir_i=0) → d=0x04 from T3. T4: dr_ld + mem_rd. T5: ac_ld with alu_op=PASS_DR. The next cycle is T0, for a total of 6 cycles.
- ADD indirect (ir_op=1, ir_i=1) → T3: mem_rd, ar_ld, bus=7. T5: alu_op=ADD, ac_ld. Then back to T0.
- ISZ (ir_op=6): run once with dr_zero=1 at T6 and once with dr_zero=0. Require pc_inc=1 and pc_inc=0 respectively, mem_wr=1 with bus_sel=3 in both, and 7 cycles per instruction.
- BSA (ir_op=5) → T4: mem_wr, ar_inc, bus=2. T5: pc_ld, bus=1. Then T0.
- HLT (ir_op=7, ir_i=0, ir_b0=1) → reg_exec at T3, running=0 after that edge, t=0 thereafter. A start pulse during the run is ignored. rst_n=0 at T4 of an STA gives t=0, mem_wr=0 immediately.
